// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: mode-0 SPI slave receive front end with synchronisers and a one-entry valid/ready holding register
module spi_rx_ctrl #(
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    input  logic                 bit_done,
    output logic                 shift_strobe,
    output logic                 cnt_clear,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun
);
    typedef enum logic {IDLE, RECV} state_t;

    state_t state_q, state_d;
    logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
    logic strobe_q, strobe_d, done_arm_q, done_arm_d;
    logic rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic [WORD_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic sck_rise, shift_en, capture, accept, frame_start;

    // Event decode; bit_done is honoured only the cycle after a strobe because the counter holds its flag
    always_comb begin
        sck_rise    = sck_sync_q & ~sck_prev_q;
        shift_en    = (state_q == RECV) & sck_rise & ~ss_sync_q;
        capture     = (state_q == RECV) & bit_done & done_arm_q;
        accept      = capture & (~rx_valid_q | rx_ready);
        frame_start = (state_q == IDLE) & ~ss_sync_q;
    end

    // Next values for synchronisers, shift register and holding register
    always_comb begin
        sck_meta_d  = sck;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        ss_meta_d   = ss_n;
        ss_sync_d   = ss_meta_q;
        mosi_meta_d = mosi;
        mosi_sync_d = mosi_meta_q;
        shift_d     = (state_q == IDLE) ? '0 : shift_en ? {shift_q[WORD_BITS-2:0], mosi_sync_q} : shift_q;
        strobe_d    = shift_en;
        done_arm_d  = strobe_q;
        rx_data_d   = accept ? shift_q : rx_data_q;
        rx_valid_d  = accept | (rx_valid_q & ~rx_ready);
        overrun_d   = frame_start ? 1'b0 : overrun_q | (capture & rx_valid_q & ~rx_ready);
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a frame opens on select low and closes on select high
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && !ss_sync_q) state_d = RECV;
        if (state_q == RECV && ss_sync_q)  state_d = IDLE;
    end

    // FSM outputs: the bit counter is held clear while idle
    always_comb begin
        cnt_clear = (state_q == IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            shift_q     <= '0;
            strobe_q    <= 1'b0;
            done_arm_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            ss_meta_q   <= ss_meta_d;
            ss_sync_q   <= ss_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            shift_q     <= shift_d;
            strobe_q    <= strobe_d;
            done_arm_q  <= done_arm_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign shift_strobe = strobe_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: directed and randomized frames checked against a word-level expectation model
module tb_spi_rx_ctrl;
    localparam int W = 16;

    logic clk = 1'b0, n_rst = 1'b0, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0, rx_ready = 1'b0;
    logic bit_done, shift_strobe, cnt_clear, rx_valid, overrun;
    logic [W-1:0] rx_data;

    int passed = 0, total = 0;
    int cyc = 0, strobes = 0, last_strobe = 0, valid_rise = 0, clr_hi = 0;
    bit prev_valid = 1'b0, in_window = 1'b0;
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    int cnt = 0;

    spi_rx_ctrl #(.WORD_BITS(W)) dut (
        .clk(clk), .n_rst(n_rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .bit_done(bit_done), .shift_strobe(shift_strobe), .cnt_clear(cnt_clear),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bit counter stand-in: counts strobes 1..W, wraps to 1, flag held while the count equals W
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || cnt_clear) begin
            cnt      <= 0;
            bit_done <= 1'b0;
        end else if (shift_strobe) begin
            cnt      <= (cnt == W) ? 1 : cnt + 1;
            bit_done <= ((cnt == W) ? 1 : cnt + 1) == W;
        end
    end

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (shift_strobe) begin
            strobes++;
            last_strobe = cyc;
        end
        if (rx_valid && !prev_valid) valid_rise = cyc;
        prev_valid = rx_valid;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (in_window && cnt_clear) clr_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_open();
        ss_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_close();
        sck = 1'b0;
        tick(4);
        ss_n = 1'b1;
        tick(8);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int hp);
        for (int i = W - 1; i >= W - n; i--) begin
            mosi = w[i];
            sck  = 1'b0;
            tick(hp);
            sck  = 1'b1;
            tick(hp);
        end
    endtask

    task automatic read_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic check_queue(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_cnt_clear", cnt_clear, 1);
        chk("rst_strobe", shift_strobe, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 16'h0000);
        chk("rst_overrun", overrun, 0);
        n_rst = 1'b1;
        tick(4);

        // Single word, 8 clk per SCK period
        strobes = 0;
        frame_open();
        send_bits(16'hA5C3, 16, 4);
        frame_close();
        chk("single_strobes", strobes, 16);
        chk("single_valid", rx_valid, 1);
        chk("single_data", rx_data, 16'hA5C3);
        chk("single_latency", valid_rise - last_strobe, 2);
        read_one();
        chk("single_drained", rx_valid, 0);
        exp_q.push_back(16'hA5C3);
        check_queue("single_read");

        // Back-to-back words with the consumer always ready
        rx_ready = 1'b1;
        clr_hi = 0;
        frame_open();
        in_window = 1'b1;
        send_bits(16'h1234, 16, 4);
        send_bits(16'hBEEF, 16, 4);
        sck = 1'b0;
        tick(4);
        in_window = 1'b0;
        frame_close();
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hBEEF);
        check_queue("b2b");
        chk("b2b_overrun", overrun, 0);
        chk("b2b_no_clear", clr_hi, 0);

        // Overrun with the consumer stalled
        rx_ready = 1'b0;
        frame_open();
        send_bits(16'h0F0F, 16, 4);
        send_bits(16'hF0F0, 16, 4);
        frame_close();
        chk("ovr_data", rx_data, 16'h0F0F);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_flag", overrun, 1);
        ss_n = 1'b0;
        tick(6);
        chk("ovr_cleared", overrun, 0);
        ss_n = 1'b1;
        tick(6);
        read_one();
        exp_q.push_back(16'h0F0F);
        check_queue("ovr_read");

        // Abort after 7 bits, then a clean frame
        rx_ready = 1'b1;
        strobes = 0;
        frame_open();
        send_bits(16'($urandom), 7, 4);
        frame_close();
        chk("abort_strobes", strobes, 7);
        chk("abort_cnt_clear", cnt_clear, 1);
        check_queue("abort_none");
        frame_open();
        send_bits(16'h8001, 16, 4);
        frame_close();
        exp_q.push_back(16'h8001);
        check_queue("abort_next");

        // Asynchronous reset mid-frame
        frame_open();
        send_bits(16'hFFFF, 9, 4);
        #3;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_cnt_clear", cnt_clear, 1);
        chk("mid_rst_strobe", shift_strobe, 0);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_data", rx_data, 16'h0000);
        chk("mid_rst_overrun", overrun, 0);
        ss_n = 1'b1;
        sck  = 1'b0;
        tick(2);
        n_rst = 1'b1;
        tick(4);
        got.delete();
        frame_open();
        send_bits(16'h5555, 16, 4);
        frame_close();
        exp_q.push_back(16'h5555);
        check_queue("after_rst");

        // Randomized frames: random word counts, data and SCK half periods
        for (int f = 0; f < 6; f++) begin
            int nw, hp;
            logic [W-1:0] w;
            nw = $urandom_range(1, 3);
            hp = $urandom_range(3, 6);
            strobes = 0;
            frame_open();
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                exp_q.push_back(w);
                send_bits(w, 16, hp);
            end
            frame_close();
            chk($sformatf("rand%0d_strobes", f), strobes, 16 * nw);
            check_queue($sformatf("rand%0d", f));
            chk($sformatf("rand%0d_overrun", f), overrun, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_rx_ctrl.md
# spi_rx_ctrl

SPI slave receive front end (mode 0, MSB first) for the FIR SPI path. It sits directly upstream of the bit-count `flex_counter`:
- it synchronises the external SCK, SS_n and MOSI pins;
- it drives the counter's `count_enable` and `clear`;
- it takes the counter's `rollover_flag` back as its word-complete indication.

Assembled words are presented on a one-entry valid/ready holding register to the downstream sample logic.

## Interface
- `WORD_BITS`, default 16: bits per SPI word. The companion counter is built with `rollover_val = WORD_BITS`.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `n_rst`, input, 1: reset, asynchronous and active-low.
- `sck`, input, 1: SPI clock from the master. It is asynchronous to `clk`.
- `ss_n`, input, 1: SPI slave select, active-low. It is asynchronous to `clk`.
- `mosi`, input, 1: SPI data from the master. It is asynchronous to `clk`.
- `bit_done`, input, 1: rollover_flag from the bit counter.
- `shift_strobe`, output, 1: one-cycle pulse per received bit. It drives the counter's count_enable.
- `cnt_clear`, output, 1: drives the counter's clear input.
- `rx_data`, output, WORD_BITS: holding register contents.
- `rx_valid`, output, 1: the holding register holds an unread word.
- `rx_ready`, input, 1: the consumer accepts `rx_data` in this cycle.
- `overrun`, output, 1: sticky flag, set when a completed word was dropped.

## Operation
**Synchronisers**
- `sck`, `ss_n` and `mosi` each pass through a 2-flop synchroniser, giving `s_sck`, `s_ss_n` and `s_mosi`.
- Synchroniser reset values: `sck` chain 0, `ss_n` chain 1, `mosi` chain 0.
- `sck_prev` register, reset value 0.
- SCK rising edge is detected as `s_sck & ~sck_prev`.

**FSM, states IDLE and RECV (reset state IDLE)**
- IDLE:
  - `cnt_clear` = 1.
  - The shift register is held at 0.
  - SCK edges are ignored.
  - Go to RECV when `s_ss_n` = 0.
- RECV:
  - `cnt_clear` = 0.
  - On each detected rising edge while `s_ss_n` = 0, shift `s_mosi` into the shift register LSB, old bits moving toward the MSB.
  - On the same clock edge, register `shift_strobe` = 1 for the following cycle.
  - When `bit_done` = 1, capture the shift register into the holding register and stay in RECV.
  - The counter wraps to 1 by itself, so back-to-back words need no clear.
  - Go to IDLE when `s_ss_n` = 1.
  - Any partial word is discarded: no capture, no `rx_valid`.

**Holding register**
- Capture when `rx_valid` = 0: load `rx_data` and set `rx_valid`.
- `rx_valid & rx_ready` with no capture in the same cycle: clear `rx_valid`. `rx_data` holds its value.
- Capture and `rx_valid & rx_ready` in the same cycle: load the new word and keep `rx_valid` = 1. `overrun` is not set.
- Capture while `rx_valid = 1 & rx_ready = 0`:
  - The new word is dropped and the old word is kept.
  - `overrun` is set.
- `overrun` clears on the IDLE→RECV transition, i.e. at the start of the next frame.

**Simultaneous events**
- `bit_done` = 1 in the same cycle as `s_ss_n` = 1: the capture completes, then the FSM goes to IDLE.
- A rising edge detected in the cycle `s_ss_n` goes high: no shift and no strobe.

## Timing
- Reset values:
  - `shift_strobe` = 0, `cnt_clear` = 1 (IDLE).
  - `rx_data` = 0, `rx_valid` = 0, `overrun` = 0.
  - Shift register = 0, state = IDLE.
- Pin-to-sync latency: 2 `clk` edges.
- Let N be the cycle in which `s_sck` = 1 and `sck_prev` = 0.
  - Cycle N+1: `shift_strobe` = 1 and the shift register already holds the new bit.
  - Cycle N+2: `bit_done` arrives from the counter, for the WORD_BITS-th bit.
  - End of cycle N+2: capture.
  - Cycle N+3: `rx_valid` = 1.
- Required SCK high and low times: at least 3 `clk` periods each. Strobes are therefore at least 3 cycles apart.
- `bit_done` outside RECV is ignored.
- `n_rst` asserted mid-frame clears everything to the reset values immediately, regardless of `clk`.

## Test plan
1. **Reset check:** assert `n_rst` = 0 with `ss_n` = 1 → `cnt_clear` = 1, `shift_strobe` = 0, `rx_valid` = 0, `rx_data` = 0x0000, `overrun` = 0.
2. **Single word:**
   - Stimulus: frame 0xA5C3, SCK at 8 `clk` per period, then `ss_n` high.
   - Response: exactly 16 `shift_strobe` pulses, then `rx_valid` = 1 with `rx_data` = 0xA5C3 three cycles after the 16th synchronised edge.
3. **Back-to-back words:**
   - Stimulus: 0x1234 then 0xBEEF with `ss_n` held low and `rx_ready` = 1.
   - Response: two `rx_valid` pulses with data 0x1234 then 0xBEEF; `overrun` = 0; `cnt_clear` = 0 throughout.
4. **Overrun:**
   - Stimulus: 0x0F0F then 0xF0F0 with `rx_ready` = 0.
   - Response: `rx_data` stays 0x0F0F; `overrun` = 1 after the second word.
   - A new frame start clears `overrun`.
5. **Abort:**
   - Stimulus: 7 bits shifted, then `ss_n` high; next frame sends 0x8001.
   - Response: no `rx_valid` after the aborted bits; `cnt_clear` = 1 in IDLE; the next frame yields `rx_data` = 0x8001.
6. **Reset mid-frame:** pulse `n_rst` low after 9 bits → all outputs return to their reset values immediately; a following full frame 0x5555 is received correctly.
